// File: rtl/tlb_refill_walker.sv
// TLB refill engine: walks the even/odd PTE pair for a missed VPN2 and
// programs the MMU through its register-write / random-write command port.
`ifndef MMU_CMD_T
`define MMU_CMD_T                logic [2:0]
`define MMU_CMD_NONE             3'd0
`define MMU_CMD_WRITE_REG        3'd1
`define MMU_CMD_WRITE_TLB_RANDOM 3'd4
`define MMU_REG_T                logic [3:0]
`define MMU_REG_RANDOM           4'd1
`define MMU_REG_ENTRYLO0         4'd2
`define MMU_REG_ENTRYLO1         4'd3
`define MMU_REG_PAGEMASK         4'd5
`define MMU_REG_ENTRYHI          4'd10
`endif

module tlb_refill_walker #(
  parameter int ENTRY_ADDR_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        res,
  input  logic                        miss_valid,
  input  logic [31:0]                 miss_vaddr,
  input  logic [7:0]                  asid,
  input  logic [31:0]                 pt_base,
  input  logic [ENTRY_ADDR_WIDTH-1:0] wired,
  output logic                        busy,
  output logic                        done,
  output logic                        fault,
  output logic                        mem_req,
  output logic [31:0]                 mem_addr,
  input  logic                        mem_ack,
  input  logic [31:0]                 mem_rdata,
  output `MMU_CMD_T                   mmu_cmd,
  output `MMU_REG_T                   mmu_reg,
  output logic [31:0]                 mmu_wdata
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_EVEN, S_RD_ODD, S_WR_HI, S_WR_LO0, S_WR_LO1,
    S_WR_MASK, S_WR_RAND, S_WR_TLB, S_DONE, S_FAULT
  } state_t;

  localparam logic [ENTRY_ADDR_WIDTH-1:0] LAST_SLOT = '1;

  state_t                      r_state, w_state_nxt;
  logic                        r_busy, r_done, r_fault, r_mem_req;
  logic [31:0]                 r_mem_addr, r_mmu_wdata;
  `MMU_CMD_T                   r_mmu_cmd;
  `MMU_REG_T                   r_mmu_reg;
  logic [ENTRY_ADDR_WIDTH-1:0] r_victim;

  logic [18:0]                 r_vpn2;
  logic [7:0]                  r_asid;
  logic [31:0]                 r_pte_addr, r_lo0, r_lo1;

  logic                        w_busy_nxt, w_done_nxt, w_fault_nxt, w_mem_req_nxt;
  logic [31:0]                 w_mem_addr_nxt, w_wdata_nxt, w_pte_addr_in;
  `MMU_CMD_T                   w_cmd_nxt;
  `MMU_REG_T                   w_reg_nxt;
  logic [ENTRY_ADDR_WIDTH-1:0] w_slot, w_victim_nxt;
  logic                        w_unused;

  assign w_unused      = ^miss_vaddr[12:0];
  assign w_pte_addr_in = pt_base + {miss_vaddr[31:13], 3'b000};

  // Wired slots are never victims; rotation runs downward and wraps to the top.
  assign w_slot       = (r_victim < wired) ? LAST_SLOT : r_victim;
  assign w_victim_nxt = (w_slot <= wired) ? LAST_SLOT : w_slot - ENTRY_ADDR_WIDTH'(1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (miss_valid) w_state_nxt = S_RD_EVEN;
      S_RD_EVEN: if (mem_ack)    w_state_nxt = S_RD_ODD;
      S_RD_ODD:  if (mem_ack)    w_state_nxt = (!r_lo0[1] && !mem_rdata[1]) ? S_FAULT : S_WR_HI;
      S_WR_HI:   w_state_nxt = S_WR_LO0;
      S_WR_LO0:  w_state_nxt = S_WR_LO1;
      S_WR_LO1:  w_state_nxt = S_WR_MASK;
      S_WR_MASK: w_state_nxt = S_WR_RAND;
      S_WR_RAND: w_state_nxt = S_WR_TLB;
      S_WR_TLB:  w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      S_FAULT:   w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    w_busy_nxt     = (w_state_nxt != S_IDLE);
    w_done_nxt     = 1'b0;
    w_fault_nxt    = 1'b0;
    w_mem_req_nxt  = 1'b0;
    w_mem_addr_nxt = r_mem_addr;
    w_cmd_nxt      = `MMU_CMD_NONE;
    w_reg_nxt      = '0;
    w_wdata_nxt    = '0;
    case (w_state_nxt)
      S_RD_EVEN: begin
        w_mem_req_nxt  = 1'b1;
        w_mem_addr_nxt = (r_state == S_IDLE) ? w_pte_addr_in : r_pte_addr;
      end
      S_RD_ODD: begin
        w_mem_req_nxt  = 1'b1;
        w_mem_addr_nxt = r_pte_addr + 32'd4;
      end
      S_WR_HI: begin
        w_cmd_nxt   = `MMU_CMD_WRITE_REG;
        w_reg_nxt   = `MMU_REG_ENTRYHI;
        w_wdata_nxt = {r_vpn2, 5'b00000, r_asid};
      end
      S_WR_LO0: begin
        w_cmd_nxt   = `MMU_CMD_WRITE_REG;
        w_reg_nxt   = `MMU_REG_ENTRYLO0;
        w_wdata_nxt = r_lo0;
      end
      S_WR_LO1: begin
        w_cmd_nxt   = `MMU_CMD_WRITE_REG;
        w_reg_nxt   = `MMU_REG_ENTRYLO1;
        w_wdata_nxt = r_lo1;
      end
      S_WR_MASK: begin
        w_cmd_nxt   = `MMU_CMD_WRITE_REG;
        w_reg_nxt   = `MMU_REG_PAGEMASK;
      end
      S_WR_RAND: begin
        w_cmd_nxt   = `MMU_CMD_WRITE_REG;
        w_reg_nxt   = `MMU_REG_RANDOM;
        w_wdata_nxt = {{(32-ENTRY_ADDR_WIDTH){1'b0}}, w_slot};
      end
      S_WR_TLB: w_cmd_nxt   = `MMU_CMD_WRITE_TLB_RANDOM;
      S_DONE:   w_done_nxt  = 1'b1;
      S_FAULT:  w_fault_nxt = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mmu_cmd   <= `MMU_CMD_NONE;
      r_mmu_reg   <= '0;
      r_mmu_wdata <= '0;
      r_victim    <= LAST_SLOT;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_fault     <= w_fault_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mmu_cmd   <= w_cmd_nxt;
      r_mmu_reg   <= w_reg_nxt;
      r_mmu_wdata <= w_wdata_nxt;
      if (r_state == S_WR_TLB) r_victim <= w_victim_nxt;
    end
  end

  // Walk operands: captured at acceptance or on read completion, held for the walk.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && miss_valid) begin
      r_vpn2     <= miss_vaddr[31:13];
      r_asid     <= asid;
      r_pte_addr <= w_pte_addr_in;
    end
    if (r_state == S_RD_EVEN && mem_ack) r_lo0 <= mem_rdata;
    if (r_state == S_RD_ODD && mem_ack)  r_lo1 <= mem_rdata;
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign fault     = r_fault;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mmu_cmd   = r_mmu_cmd;
  assign mmu_reg   = r_mmu_reg;
  assign mmu_wdata = r_mmu_wdata;

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Bench for tlb_refill_walker: directed scenarios plus randomized walks checked
// against a transaction-level model of reads, MMU commands and victim rotation.
`ifndef MMU_CMD_T
`define MMU_CMD_T                logic [2:0]
`define MMU_CMD_NONE             3'd0
`define MMU_CMD_WRITE_REG        3'd1
`define MMU_CMD_WRITE_TLB_RANDOM 3'd4
`define MMU_REG_T                logic [3:0]
`define MMU_REG_RANDOM           4'd1
`define MMU_REG_ENTRYLO0         4'd2
`define MMU_REG_ENTRYLO1         4'd3
`define MMU_REG_PAGEMASK         4'd5
`define MMU_REG_ENTRYHI          4'd10
`endif

module tb_tlb_refill_walker;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          res = 1'b1;
  logic          miss_valid = 1'b0;
  logic [31:0]   miss_vaddr = '0;
  logic [7:0]    asid = '0;
  logic [31:0]   pt_base = '0;
  logic [AW-1:0] wired = '0;
  logic          busy, done, fault, mem_req;
  logic [31:0]   mem_addr;
  logic          mem_ack = 1'b0;
  logic [31:0]   mem_rdata = '0;
  `MMU_CMD_T     mmu_cmd;
  `MMU_REG_T     mmu_reg;
  logic [31:0]   mmu_wdata;

  typedef struct {
    int          cyc;
    logic [2:0]  cmd;
    logic [3:0]  rg;
    logic [31:0] wd;
  } cmd_t;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mem [logic [31:0]];
  int  ack_wait = 0;
  bit  ack_noise = 1'b0;
  int  wcnt = 0;
  int  model_victim = 7;
  logic [31:0] last_rand;

  tlb_refill_walker #(.ENTRY_ADDR_WIDTH(AW)) dut (
    .clk(clk), .res(res), .miss_valid(miss_valid), .miss_vaddr(miss_vaddr),
    .asid(asid), .pt_base(pt_base), .wired(wired), .busy(busy), .done(done),
    .fault(fault), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mmu_cmd(mmu_cmd), .mmu_reg(mmu_reg), .mmu_wdata(mmu_wdata)
  );

  always #5 clk = ~clk;

  // Memory responder: ack after ack_wait idle cycles of an outstanding request.
  always @(posedge clk) begin
    #2;
    if (mem_req) begin
      if (wcnt >= ack_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'hDEAD_BEEF;
        wcnt      = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      wcnt      = 0;
      mem_ack   = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    model_victim = 2 ** AW - 1;
  endtask

  task automatic run_walk(input string tag, input logic [31:0] va, input logic [7:0] as,
                          input logic [31:0] pb, input logic [31:0] l0, input logic [31:0] l1,
                          input int wt, input bit hold);
    logic [31:0] pte, prev_addr;
    bit          valid, prev_req, prev_ack;
    int          lat, end_c, done_c, fault_c, slot;
    cmd_t        exp_q[$];
    cmd_t        obs_q[$];
    logic [31:0] rd_q[$];

    pte   = pb + ((va >> 13) << 3);
    mem[pte] = l0;
    mem[pte + 32'd4] = l1;
    ack_wait = wt;
    valid = l0[1] | l1[1];
    lat   = 2 * wt;
    slot  = (model_victim < int'(wired)) ? 2 ** AW - 1 : model_victim;
    if (valid) begin
      exp_q.push_back('{3 + lat, `MMU_CMD_WRITE_REG, `MMU_REG_ENTRYHI, (va & 32'hFFFF_E000) | {24'h0, as}});
      exp_q.push_back('{4 + lat, `MMU_CMD_WRITE_REG, `MMU_REG_ENTRYLO0, l0});
      exp_q.push_back('{5 + lat, `MMU_CMD_WRITE_REG, `MMU_REG_ENTRYLO1, l1});
      exp_q.push_back('{6 + lat, `MMU_CMD_WRITE_REG, `MMU_REG_PAGEMASK, 32'h0});
      exp_q.push_back('{7 + lat, `MMU_CMD_WRITE_REG, `MMU_REG_RANDOM, 32'(slot)});
      exp_q.push_back('{8 + lat, `MMU_CMD_WRITE_TLB_RANDOM, 4'h0, 32'h0});
    end

    @(negedge clk);
    miss_vaddr = va; asid = as; pt_base = pb; miss_valid = 1'b1;
    end_c = 0; done_c = 0; fault_c = 0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    for (int c = 1; c <= 80 && end_c == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk({tag, "/busy_start"}, 32'(busy), 32'd1);
        if (!hold) begin
          miss_valid = 1'b0;
          miss_vaddr = $urandom; asid = 8'($urandom); pt_base = $urandom & 32'hFFFF_FFFC;
        end
      end
      if (mem_req && prev_req && !prev_ack) chk({tag, "/addr_stable"}, mem_addr, prev_addr);
      if (mem_req && mem_ack) rd_q.push_back(mem_addr);
      prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr;
      if (mmu_cmd !== `MMU_CMD_NONE) obs_q.push_back('{c, mmu_cmd, mmu_reg, mmu_wdata});
      if (done)  done_c = c;
      if (fault) fault_c = c;
      if (done || fault) end_c = c;
    end
    chk({tag, "/walk_ended"}, 32'(end_c != 0), 32'd1);
    chk({tag, "/done_cycle"}, 32'(done_c), valid ? 32'(9 + lat) : 32'd0);
    chk({tag, "/fault_cycle"}, 32'(fault_c), valid ? 32'd0 : 32'(3 + lat));
    chk({tag, "/n_reads"}, 32'(rd_q.size()), 32'd2);
    if (rd_q.size() > 0) chk({tag, "/rd_even"}, rd_q[0], pte);
    if (rd_q.size() > 1) chk({tag, "/rd_odd"}, rd_q[1], pte + 32'd4);
    chk({tag, "/n_cmds"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("%s/cmd%0d_cyc", tag, i), 32'(obs_q[i].cyc), 32'(exp_q[i].cyc));
      chk($sformatf("%s/cmd%0d_op", tag, i), 32'(obs_q[i].cmd), 32'(exp_q[i].cmd));
      if (exp_q[i].cmd == `MMU_CMD_WRITE_REG) begin
        chk($sformatf("%s/cmd%0d_reg", tag, i), 32'(obs_q[i].rg), 32'(exp_q[i].rg));
        chk($sformatf("%s/cmd%0d_data", tag, i), obs_q[i].wd, exp_q[i].wd);
        if (exp_q[i].rg == `MMU_REG_RANDOM) last_rand = obs_q[i].wd;
      end
    end
    if (valid) model_victim = (slot <= int'(wired)) ? 2 ** AW - 1 : slot - 1;

    @(negedge clk);
    chk({tag, "/idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "/pulse_len"}, 32'(done | fault), 32'd0);
    if (hold) begin
      @(negedge clk);
      chk({tag, "/rewalk_busy"}, 32'(busy), 32'd1);
      chk({tag, "/rewalk_req"}, 32'(mem_req), 32'd1);
      chk({tag, "/rewalk_addr"}, mem_addr, pte);
      miss_valid = 1'b0;
    end
  endtask

  initial begin
    int rot_exp [5];
    int bad;
    logic [31:0] l0, l1;
    rot_exp = '{7, 6, 5, 7, 6};

    // Reset state
    #12;
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/done", 32'(done), 32'd0);
    chk("rst/fault", 32'(fault), 32'd0);
    chk("rst/mem_req", 32'(mem_req), 32'd0);
    chk("rst/mem_addr", mem_addr, 32'd0);
    chk("rst/wdata", mmu_wdata, 32'd0);
    chk("rst/cmd", 32'(mmu_cmd), 32'(`MMU_CMD_NONE));
    chk("rst/reg", 32'(mmu_reg), 32'd0);
    @(negedge clk);
    res = 1'b0;

    run_walk("basic", 32'h0040_3ABC, 8'h05, 32'h0010_0000, 32'h0000_1006, 32'h0000_2007, 0, 1'b0);
    chk("basic/random", last_rand, 32'd7);
    run_walk("wrap", 32'h0000_4000, 8'h11, 32'hFFFF_FFF0, 32'h0000_3002, 32'h0000_4000, 0, 1'b0);
    run_walk("invalid", 32'h1234_5000, 8'h22, 32'h0020_0000, 32'h0000_1000, 32'h0000_2000, 0, 1'b0);
    run_walk("after_inv", 32'h2000_0000, 8'h23, 32'h0030_0000, 32'h0000_1001, 32'h0000_2002, 1, 1'b0);

    pulse_reset();
    wired = 3'd5;
    for (int k = 0; k < 5; k++) begin
      run_walk($sformatf("rot%0d", k), 32'h0800_0000 + 32'(k) * 32'h2000, 8'(k), 32'h0040_0000,
               32'h0000_5006, 32'h0000_6006, 0, 1'b0);
      chk($sformatf("rot%0d/random", k), last_rand, 32'(rot_exp[k]));
    end

    pulse_reset();
    run_walk("wait", 32'h0040_3ABC, 8'h05, 32'h0010_0000, 32'h0000_1006, 32'h0000_2007, 3, 1'b1);
    pulse_reset();

    // Reset asserted during WR_LO1
    ack_wait = 0;
    @(negedge clk);
    miss_vaddr = 32'h0060_0000; asid = 8'h44; pt_base = 32'h0050_0000; miss_valid = 1'b1;
    mem[32'h0050_0000 + 32'h0000_1800] = 32'h0000_7006;
    mem[32'h0050_0000 + 32'h0000_1804] = 32'h0000_8006;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) miss_valid = 1'b0;
    end
    chk("rstmid/in_lo1", 32'(mmu_reg), 32'(`MMU_REG_ENTRYLO1));
    #2 res = 1'b1;
    #1;
    chk("rstmid/mem_req", 32'(mem_req), 32'd0);
    chk("rstmid/cmd", 32'(mmu_cmd), 32'(`MMU_CMD_NONE));
    chk("rstmid/busy", 32'(busy), 32'd0);
    @(negedge clk);
    res = 1'b0;
    model_victim = 2 ** AW - 1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy || mmu_cmd !== `MMU_CMD_NONE) bad++;
    end
    chk("rstmid/quiet", 32'(bad), 32'd0);
    run_walk("post_rst", 32'h0060_0000, 8'h44, 32'h0050_0000, 32'h0000_7006, 32'h0000_8006, 0, 1'b0);

    // Randomized walks
    ack_noise = 1'b1;
    for (int k = 0; k < 24; k++) begin
      wired = AW'($urandom_range(0, 7));
      l0 = $urandom; l1 = $urandom;
      if ($urandom_range(0, 3) == 0) begin l0[1] = 1'b0; l1[1] = 1'b0; end
      run_walk($sformatf("rnd%0d", k), $urandom, 8'($urandom), $urandom & 32'hFFFF_FFFC,
               l0, l1, $urandom_range(0, 3), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tlb_refill_walker.md
# tlb_refill_walker

Hardware TLB refill engine that sits beside the MMU on its command interface. On a TLB miss it fetches the even/odd page-table entry pair from memory and loads them into a TLB slot. It does this by driving the MMU's register-write and random-write commands, so the MMU's own command port is the receiving end. Victim slots rotate round-robin above the wired boundary, which takes the place of a free-running Random register.

## Interface
- ENTRY_ADDR_WIDTH, 3, log2 of MMU TLB entry count (ENTRY_COUNT = 1 << ENTRY_ADDR_WIDTH)

Ports:
- clk  in  1  clock, all state on rising edge
- res  in  1  reset, asynchronous, active-high
- miss_valid  in  1  MMU reported `MMU_EXCEPTION_TLBMISS; level, sampled only in IDLE
- miss_vaddr  in  32  faulting virtual address
- asid  in  8  current address-space id
- pt_base  in  32  page-table base (byte address, 4-byte aligned)
- wired  in  ENTRY_ADDR_WIDTH  first non-wired TLB slot
- busy  out  1  walk in progress (any state but IDLE)
- done  out  1  one-cycle pulse: TLB entry written
- fault  out  1  one-cycle pulse: both PTEs invalid, nothing written
- mem_req  out  1  read request
- mem_addr  out  32  read address
- mem_ack  in  1  read complete, mem_rdata valid this cycle
- mem_rdata  in  32  read data
- mmu_cmd  out  `MMU_CMD_T  command to MMU
- mmu_reg  out  `MMU_REG_T  register select
- mmu_wdata  out  32  data to MMU mmu_dataIn

## Operation
- States: IDLE, RD_EVEN, RD_ODD, WR_HI, WR_LO0, WR_LO1, WR_MASK, WR_RAND, WR_TLB, DONE, FAULT.
- IDLE with miss_valid=1:
  - capture vpn2 = miss_vaddr[31:13], plus asid and pt_base;
  - compute pte_addr = pt_base + {vpn2, 3'b000}, mod 2^32 (wraps silently);
  - go to RD_EVEN.
- RD_EVEN:
  - mem_req=1, mem_addr=pte_addr;
  - on mem_ack, latch lo0 = mem_rdata and go to RD_ODD.
- RD_ODD:
  - mem_req=1, mem_addr=pte_addr+4 (mod 2^32);
  - on mem_ack, latch lo1;
  - if lo0[1]==0 and lo1[1]==0, go to FAULT, else go to WR_HI.
- PTEs are used verbatim as EntryLo format: [1]=V, [0]=G, [2]=D as the MMU interprets them.
- WR_HI: mmu_cmd=`MMU_CMD_WRITE_REG, mmu_reg=`MMU_REG_ENTRYHI, mmu_wdata={vpn2, 5'b0, asid}.
- WR_LO0 and WR_LO1: write `MMU_REG_ENTRYLO0 = lo0 and `MMU_REG_ENTRYLO1 = lo1.
- WR_MASK: write `MMU_REG_PAGEMASK = 0 (4 KB pages only).
- WR_RAND: write `MMU_REG_RANDOM = slot.
  - slot = (victim < wired) ? ENTRY_COUNT-1 : victim, zero-extended to 32 bits.
- WR_TLB: mmu_cmd=`MMU_CMD_WRITE_TLB_RANDOM; victim updates this cycle:
  - next = (slot <= wired) ? ENTRY_COUNT-1 : slot-1.
- DONE: done=1, then IDLE. FAULT: fault=1, then IDLE; victim is unchanged.
- In every state other than the WR_* states, mmu_cmd=`MMU_CMD_NONE.
- miss_valid is ignored while busy. Inputs captured at acceptance are held for the whole walk.
- Reset values:
  - state IDLE; busy, done, fault, mem_req = 0;
  - mem_addr = 0, mmu_wdata = 0;
  - mmu_cmd = `MMU_CMD_NONE, mmu_reg = 0;
  - victim = ENTRY_COUNT-1.
- Reset asserted mid-walk: immediately return to reset values, including mem_req dropping asynchronously. No partial command sequence resumes; the MMU may already hold written registers but no TLB write occurs.

## Timing
- All outputs are registered and reflect the current state.
- Memory handshake:
  - mem_req and mem_addr are stable until the cycle mem_ack=1;
  - data is taken on that edge;
  - mem_req may stay high into the next read with a new address;
  - mem_ack while mem_req=0 is ignored.
- Minimum latency with zero-wait ack, miss accepted at edge 0:
  - RD_EVEN in cycle 1, RD_ODD in cycle 2;
  - WR_HI through WR_TLB in cycles 3–8, one MMU command per cycle, no gaps;
  - done=1 in cycle 9; IDLE in cycle 10; a new miss is accepted at the end of cycle 10.
- Fault path: FAULT (fault=1) in cycle 3, IDLE in cycle 4.
- Each wait cycle on mem_ack adds one cycle. There is no timeout.

## Test plan
- Basic refill:
  - stimulus: pt_base=0x0010_0000, miss_vaddr=0x0040_3ABC, asid=0x05, lo0=0x0000_1006, lo1=0x0000_2007, zero-wait ack;
  - response: reads at 0x0010_1008 then 0x0010_100C; EntryHi=0x0040_2005, Lo0=0x1006, Lo1=0x2007, PageMask=0, Random=7, WRITE_TLB_RANDOM in cycle 8; done in cycle 9.
- Address wrap:
  - stimulus: pt_base=0xFFFF_FFF0, miss_vaddr=0x0000_4000;
  - response: reads at 0x0000_0000 and 0x0000_0004.
- Invalid pair:
  - stimulus: lo0=0x1000, lo1=0x2000;
  - response: fault pulse in cycle 3, no WRITE_REG/WRITE_TLB commands, victim unchanged.
- Victim rotation:
  - stimulus: ENTRY_ADDR_WIDTH=3, wired=5, five successive refills;
  - response: Random written 7, 6, 5, 7, 6.
- Wait states and busy:
  - stimulus: mem_ack delayed 3 cycles per read; miss_valid held high throughout;
  - response: mem_addr stable while waiting; done in cycle 15; the next walk starts only after returning to IDLE.
- Reset mid-walk:
  - stimulus: assert res during WR_LO1;
  - response: mem_req=0, mmu_cmd=`MMU_CMD_NONE, busy=0 without waiting for a clock edge; no WRITE_TLB_RANDOM is ever issued; the next miss walks from RD_EVEN.
